// File: rtl/soc_prog_pkg.sv
// Shared constants and state type for the UART programming bridge.
package soc_prog_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_HOLD  = 8'h48;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_PING  = 8'h50;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_TX_ACK,
    ST_TX_DATA
  } prog_state_t;

endpackage

// File: rtl/soc_membus_if.sv
// Word-wide SoC memory bus between one master and the interconnect.
interface SoC_MemBus;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        write_en;
  logic [3:0]  byte_en;
  logic        req;
  logic        valid;

  modport Master (output addr, write_data, write_en, byte_en, req,
                  input  read_data, valid);
  modport Slave  (input  addr, write_data, write_en, byte_en, req,
                  output read_data, valid);
endinterface

// File: rtl/soc_prog_bridge.sv
// Decodes host command bytes into word reads/writes on the SoC bus and
// streams the response bytes back; also owns the core hold line.
module soc_prog_bridge
  import soc_prog_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  SoC_MemBus.Master  bus,
  output logic       core_hold,
  output logic       rx_overrun
);

  localparam int CNT_W = $clog2(BYTE_TIMEOUT + 1);

  prog_state_t      state_q, state_d;
  logic             is_write_q;
  logic [1:0]       idx_q, idx_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic             req_q, we_q;
  logic [3:0]       be_q;
  logic             bus_done, tx_fire, timeout;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] short_rsp(input logic [7:0] cmd);
    return (cmd == CMD_HOLD || cmd == CMD_GO || cmd == CMD_PING) ? RSP_ACK : RSP_NAK;
  endfunction

  assign bus.addr       = addr_q;
  assign bus.write_data = wdata_q;
  assign bus.write_en   = we_q;
  assign bus.byte_en    = be_q;
  assign bus.req        = req_q;

  assign bus_done = req_q && bus.valid;
  assign tx_fire  = tx_valid && tx_ready;
  assign timeout  = (cnt_q == CNT_W'(BYTE_TIMEOUT));
  assign idx_nxt  = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (rx_valid)
          state_d = (rx_data == CMD_WRITE || rx_data == CMD_READ) ? ST_ADDR : ST_TX_ACK;
      ST_ADDR:
        if (rx_valid) begin
          if (idx_q == 2'd3) state_d = is_write_q ? ST_DATA : ST_BUS;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      ST_DATA:
        if (rx_valid) begin
          if (idx_q == 2'd3) state_d = ST_BUS;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      ST_BUS:
        if (bus_done) state_d = is_write_q ? ST_TX_ACK : ST_TX_DATA;
      ST_TX_ACK:
        if (tx_fire) state_d = ST_IDLE;
      ST_TX_DATA:
        if (tx_fire && idx_q == 2'd3) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      core_hold  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Bytes arriving while a command is executing or answering are lost.
      rx_overrun <= rx_valid && (state_q == ST_BUS || state_q == ST_TX_ACK ||
                                 state_q == ST_TX_DATA);
      unique case (state_q)
        ST_IDLE: begin
          idx_q <= 2'd0;
          cnt_q <= '0;
          if (rx_valid) begin
            is_write_q <= (rx_data == CMD_WRITE);
            if (rx_data != CMD_WRITE && rx_data != CMD_READ) begin
              tx_valid <= 1'b1;
              tx_data  <= short_rsp(rx_data);
              if (rx_data == CMD_HOLD) core_hold <= 1'b1;
              if (rx_data == CMD_GO)   core_hold <= 1'b0;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (rx_valid) begin
            cnt_q <= '0;
            idx_q <= idx_nxt;
            if (state_q == ST_ADDR) addr_q[{idx_q, 3'b000} +: 8]  <= rx_data;
            else                    wdata_q[{idx_q, 3'b000} +: 8] <= rx_data;
            if (state_d == ST_BUS) begin
              req_q <= 1'b1;
              we_q  <= is_write_q;
              be_q  <= 4'hF;
            end
          end else if (timeout) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_BUS: begin
          if (bus_done) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            rdata_q  <= bus.read_data;
            idx_q    <= 2'd0;
            tx_valid <= 1'b1;
            tx_data  <= is_write_q ? RSP_ACK : bus.read_data[7:0];
          end
        end
        ST_TX_ACK: begin
          if (tx_fire) tx_valid <= 1'b0;
        end
        ST_TX_DATA: begin
          if (tx_fire) begin
            if (idx_q == 2'd3) begin
              tx_valid <= 1'b0;
            end else begin
              idx_q   <= idx_nxt;
              tx_data <= pick_byte(rdata_q, idx_nxt);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_prog_bridge.sv
// Bench for soc_prog_bridge: protocol-level model, bus slave and per-cycle compare.
module tb_soc_prog_bridge;
  import soc_prog_pkg::*;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       core_hold;
  logic       rx_overrun;

  SoC_MemBus bus_if();

  soc_prog_bridge #(.BYTE_TIMEOUT(TO)) dut (
    .clk(clk), .res(res), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus(bus_if), .core_hold(core_hold), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    checks++;
    failures++;
    $display("FAIL %s got=%h required=none", name, got);
  endtask

  // ---------------- bus slave ----------------
  logic        valid_r = 1'b0;
  logic [31:0] rdata_r = 32'h0;
  int          wcnt = 0;
  int          slave_delay = 3;
  bit          slave_comb = 1'b0;
  logic [31:0] slave_mem [logic [31:0]];

  assign bus_if.valid     = slave_comb ? bus_if.req : valid_r;
  assign bus_if.read_data = rdata_r;

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : 32'hCAFEF00D;
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!res) begin
        valid_r = 1'b0;
        wcnt = 0;
      end else if (slave_comb) begin
        rdata_r = slave_rd(bus_if.addr);
        if (bus_if.req && bus_if.write_en) slave_mem[bus_if.addr] = bus_if.write_data;
      end else if (valid_r) begin
        valid_r = 1'b0;
        wcnt = 0;
      end else if (bus_if.req) begin
        wcnt++;
        if (wcnt > slave_delay) begin
          valid_r = 1'b1;
          rdata_r = slave_rd(bus_if.addr);
          if (bus_if.write_en) slave_mem[bus_if.addr] = bus_if.write_data;
        end
      end
    end
  end

  // ---------------- protocol model ----------------
  typedef struct { logic [31:0] addr; logic [31:0] data; logic we; } txn_t;
  logic [7:0]  mbuf[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_q[$];
  txn_t        exp_bus[$];
  logic [31:0] model_mem [logic [31:0]];
  logic        exp_hold = 1'b0;
  logic        ovr_exp = 1'b0;
  int          req_cycles = 0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'hCAFEF00D;
  endfunction

  task automatic model_rx(input logic [7:0] b);
    logic [31:0] a, d;
    txn_t t;
    mbuf.push_back(b);
    if (mbuf[0] == CMD_WRITE) begin
      if (mbuf.size() == 9) begin
        a = {mbuf[4], mbuf[3], mbuf[2], mbuf[1]};
        d = {mbuf[8], mbuf[7], mbuf[6], mbuf[5]};
        t.addr = a; t.data = d; t.we = 1'b1;
        exp_bus.push_back(t);
        model_mem[a] = d;
        exp_tx.push_back(RSP_ACK);
        mbuf.delete();
      end
    end else if (mbuf[0] == CMD_READ) begin
      if (mbuf.size() == 5) begin
        a = {mbuf[4], mbuf[3], mbuf[2], mbuf[1]};
        t.addr = a; t.data = 32'h0; t.we = 1'b0;
        exp_bus.push_back(t);
        d = model_rd(a);
        for (int k = 0; k < 4; k++) exp_tx.push_back(d[8*k +: 8]);
        mbuf.delete();
      end
    end else begin
      case (b)
        CMD_HOLD: begin exp_hold = 1'b1; exp_tx.push_back(RSP_ACK); end
        CMD_GO:   begin exp_hold = 1'b0; exp_tx.push_back(RSP_ACK); end
        CMD_PING: exp_tx.push_back(RSP_ACK);
        default:  exp_tx.push_back(RSP_NAK);
      endcase
      mbuf.delete();
    end
  endtask

  task automatic model_clear();
    mbuf.delete();
    exp_tx.delete();
    exp_bus.delete();
  endtask

  // ---------------- per-cycle compare ----------------
  logic   done_prev = 1'b0;
  logic [7:0] e_byte;
  txn_t   e_txn;

  always @(negedge clk) begin
    if (!res) begin
      done_prev = 1'b0;
    end else begin
      chk("core_hold", core_hold, exp_hold);
      chk("rx_overrun", rx_overrun, ovr_exp);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          fail_now("tx_unexpected", tx_data);
        end else begin
          e_byte = exp_tx.pop_front();
          chk("tx_byte", tx_data, e_byte);
          got_q.push_back(tx_data);
        end
      end
      if (done_prev) chk("req_drop", bus_if.req, 0);
      if (bus_if.req) begin
        req_cycles++;
        if (exp_bus.size() == 0) begin
          fail_now("bus_unexpected", bus_if.addr);
        end else begin
          e_txn = exp_bus[0];
          chk("bus_addr", bus_if.addr, e_txn.addr);
          chk("bus_we", bus_if.write_en, e_txn.we);
          if (e_txn.we) begin
            chk("bus_wdata", bus_if.write_data, e_txn.data);
            chk("bus_be", bus_if.byte_en, 4'hF);
          end
          if (bus_if.valid) exp_bus.delete(0);
        end
      end else begin
        chk("we_idle", bus_if.write_en, 0);
        chk("be_idle", bus_if.byte_en, 0);
      end
      done_prev = bus_if.req && bus_if.valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit toggle_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = toggle_en ? ~tx_ready : 1'b1;
    end
  end

  typedef logic [7:0] byte_q_t[$];

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    model_rx(b);
  endtask

  task automatic send_seq(input byte_q_t bs);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && !tx_valid && !bus_if.req) ok = 1'b1;
    end
    if (!ok) fail_now(name, exp_tx.size());
  endtask

  task automatic wait_req(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus_if.req) ok = 1'b1;
    end
    if (!ok) fail_now(name, 0);
  endtask

  task automatic inject_overrun();
    @(posedge clk); #1;
    rx_data = 8'h50;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    ovr_exp = 1'b1;
    @(negedge clk);
    chk("overrun_pulse", rx_overrun, 1);
    @(posedge clk); #1;
    ovr_exp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  byte_q_t seq;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req", bus_if.req, 0);
    chk("rst_we", bus_if.write_en, 0);
    chk("rst_be", bus_if.byte_en, 0);
    chk("rst_addr", bus_if.addr, 0);
    chk("rst_wdata", bus_if.write_data, 0);
    chk("rst_hold", core_hold, 0);
    chk("rst_overrun", rx_overrun, 0);
    slave_mem[32'h1004] = 32'h12345678;
    model_mem[32'h1004] = 32'h12345678;
    res = 1'b1;

    // write, slave answers 3 cycles after req
    req_cycles = 0;
    seq = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(seq);
    wait_req("write_req_wait");
    chk("write_addr_lit", bus_if.addr, 32'h00001000);
    chk("write_data_lit", bus_if.write_data, 32'hDEADBEEF);
    chk("write_we_lit", bus_if.write_en, 1);
    chk("write_be_lit", bus_if.byte_en, 4'hF);
    wait_idle("write_done");
    chk("write_req_len", req_cycles, 4);
    chk("write_rsp_lit", got_q[$], 8'h06);

    // read under toggling tx_ready
    got_q.delete();
    toggle_en = 1'b1;
    seq = '{8'h52, 8'h04, 8'h10, 8'h00, 8'h00};
    send_seq(seq);
    wait_req("read_req_wait");
    chk("read_addr_lit", bus_if.addr, 32'h00001004);
    chk("read_we_lit", bus_if.write_en, 0);
    wait_idle("read_done");
    toggle_en = 1'b0;
    chk("read_cnt", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("read_b0", got_q[0], 8'h78);
      chk("read_b1", got_q[1], 8'h56);
      chk("read_b2", got_q[2], 8'h34);
      chk("read_b3", got_q[3], 8'h12);
    end

    // unmapped address, combinational valid
    got_q.delete();
    slave_comb = 1'b1;
    req_cycles = 0;
    seq = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h80};
    send_seq(seq);
    wait_idle("unmapped_done");
    slave_comb = 1'b0;
    chk("unmapped_req_len", req_cycles, 1);
    chk("unmapped_b0", got_q.size() > 0 ? got_q[0] : 8'hXX, 8'h0D);

    // hold / NAK / go
    send_byte(CMD_HOLD);
    wait_idle("hold_done");
    chk("hold_lit", core_hold, 1);
    send_byte(8'hAA);
    wait_idle("nak_done");
    chk("nak_lit", got_q[$], 8'h15);
    chk("nak_hold_lit", core_hold, 1);
    send_byte(CMD_GO);
    wait_idle("go_done");
    chk("go_lit", core_hold, 0);

    // gaps just under the timeout keep the command alive
    got_q.delete();
    seq = '{8'h52, 8'h04, 8'h10};
    send_seq(seq);
    repeat (TO - 10) @(posedge clk);
    seq = '{8'h00, 8'h00};
    send_seq(seq);
    wait_idle("slow_read_done");
    chk("slow_read_b3", got_q.size() == 4 ? got_q[3] : 8'hXX, 8'h12);

    // stall past the timeout
    seq = '{8'h52, 8'h00};
    send_seq(seq);
    repeat (TO + 20) @(posedge clk);
    #1;
    chk("timeout_no_tx", tx_valid, 0);
    model_clear();
    send_byte(CMD_PING);
    wait_idle("ping_after_timeout");
    chk("ping_after_timeout_lit", got_q[$], 8'h06);

    // byte injected while the bus is busy
    seq = '{8'h57, 8'h00, 8'h20, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    send_seq(seq);
    inject_overrun();
    wait_idle("overrun_write_done");
    got_q.delete();
    seq = '{8'h52, 8'h00, 8'h20, 8'h00, 8'h00};
    send_seq(seq);
    wait_idle("overrun_readback");
    chk("overrun_readback_b0", got_q.size() == 4 ? got_q[0] : 8'hXX, 8'h04);

    // reset while a read is outstanding
    slave_delay = 50;
    seq = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(seq);
    wait_req("rst_bus_req_wait");
    @(negedge clk);
    #2;
    res = 1'b0;
    #1;
    chk("rst_mid_req", bus_if.req, 0);
    chk("rst_mid_tx_valid", tx_valid, 0);
    model_clear();
    exp_hold = 1'b0;
    slave_delay = 3;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b1;
    repeat (5) @(posedge clk);
    send_byte(CMD_PING);
    wait_idle("ping_after_reset");
    chk("ping_after_reset_lit", got_q[$], 8'h06);

    chk("exp_tx_left", exp_tx.size(), 0);
    chk("exp_bus_left", exp_bus.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
